// File: rtl/cimg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cimg_pkg : shared types and helpers for the CImgBuffer bank writer
// Revision : 1.0
// ---------------------------------------------------------------------------
package cimg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DROP    = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_READY   = 2'd2
  } bank_state_e;

  // ceil(log2(value)), never less than 1 so index vectors stay legal
  function automatic int clog2_min1(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cimg_bank_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cimg_bank_writer_if : image-buffer write port (strobe, address, data)
// Revision : 1.0
// ---------------------------------------------------------------------------
interface cimg_bank_writer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              buf_wren;
  logic [ADDR_W-1:0] buf_wraddr;
  logic [DATA_W-1:0] buf_wrdata;

  modport master (output buf_wren, output buf_wraddr, output buf_wrdata);
  modport slave  (input  buf_wren, input  buf_wraddr, input  buf_wrdata);
endinterface
`default_nettype wire

// File: rtl/cimg_pixel_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cimg_pixel_packer : packs sensor samples into words, optional padded flush
// Revision : 1.0
// ---------------------------------------------------------------------------
module cimg_pixel_packer
  import cimg_pkg::*;
#(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 4
) (
  input  wire logic                          clock,
  input  wire logic                          reset_n,
  input  wire logic                          capture,
  input  wire logic                          frame_begin,
  input  wire logic                          line_valid,
  input  wire logic                          pad_en,
  input  wire logic [PIX_W-1:0]              sensor_din,
  output logic                               word_valid,
  output logic [PIX_W*PIX_PER_WORD-1:0]      word
);

  localparam int DATA_W = PIX_W * PIX_PER_WORD;
  localparam int LANE_W = clog2_min1(PIX_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PIX_PER_WORD - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              line_valid_q;

  // word_valid/word are combinational; the writer registers them into the bus
  always_comb begin
    logic              lv_rise;
    logic              lv_fall;
    logic [LANE_W-1:0] lane_eff;
    logic [DATA_W-1:0] merged;

    lv_rise  = line_valid & ~line_valid_q;
    lv_fall  = ~line_valid & line_valid_q;
    lane_eff = lv_rise ? '0 : lane_q;
    merged   = (lane_eff == '0) ? '0 : data_q;
    merged[lane_eff*PIX_W +: PIX_W] = sensor_din;

    lane_d     = lane_q;
    data_d     = data_q;
    word_valid = 1'b0;
    word       = merged;

    if (!capture || frame_begin) begin
      lane_d = '0;
      data_d = '0;
    end else if (line_valid) begin
      if (lane_eff == LAST_LANE) begin
        word_valid = 1'b1;
        lane_d     = '0;
        data_d     = '0;
      end else begin
        lane_d = lane_eff + 1'b1;
        data_d = merged;
      end
    end else if (lv_fall && (lane_q != '0)) begin
      // unused upper lanes are already zero because data clears at word start
      word_valid = pad_en;
      word       = data_q;
      lane_d     = '0;
      data_d     = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lane_q       <= '0;
      data_q       <= '0;
      line_valid_q <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      data_q       <= data_d;
      line_valid_q <= line_valid;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cimg_bank_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cimg_bank_writer : sensor-to-BRAM ring writer with per-bank ownership
// Revision : 1.0
// ---------------------------------------------------------------------------
module cimg_bank_writer
  import cimg_pkg::*;
#(
  parameter int  PIX_W        = 8,
  parameter int  PIX_PER_WORD = 4,
  parameter int  ADDR_W       = 14,
  parameter int  NUM_BANKS    = 2,
  parameter int  BANK_STRIDE  = 8192,
  localparam int BIDX_W       = clog2_min1(NUM_BANKS)
) (
  input  wire logic              clock,
  input  wire logic              reset_n,
  input  wire logic [PIX_W-1:0]  sensor_din,
  input  wire logic              frame_begin,
  input  wire logic              line_valid,
  input  wire logic              enable,
  input  wire logic              pad_en,
  input  wire logic [ADDR_W-1:0] bank_size,
  input  wire logic [7:0]        min_irq,
  input  wire logic              bank_release,
  input  wire logic [BIDX_W-1:0] release_idx,
  cimg_bank_writer_if.master     wr,
  output logic                   irq,
  output logic [BIDX_W-1:0]      irq_bank,
  output logic [NUM_BANKS-1:0]   bank_ready,
  output logic                   overflow,
  output logic                   frame_short,
  output logic [15:0]            dropped_frames
);

  localparam int DATA_W = PIX_W * PIX_PER_WORD;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BANK_STRIDE);

  wr_state_e         state_q, state_d;
  logic [BIDX_W-1:0] cur_bank_q, cur_bank_d;
  bank_state_e       bank_st_q [NUM_BANKS];
  bank_state_e       bank_st_d [NUM_BANKS];
  bank_state_e       bank_eff  [NUM_BANKS];
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] size_l_q, size_l_d;
  logic              wren_q, wren_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic              irq_q, irq_d;
  logic [BIDX_W-1:0] irq_bank_q, irq_bank_d;
  logic              overflow_q, overflow_d;
  logic              frame_short_q, frame_short_d;
  logic [15:0]       dropped_q, dropped_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              word_valid;
  logic [DATA_W-1:0] word;
  logic              write_live, complete, next_free, drop_now, capture_ok;
  logic [BIDX_W-1:0] next_bank;
  logic [ADDR_W-1:0] size_sel;

  // bank states as seen this cycle once a same-cycle release is applied
  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_eff[i] = bank_st_q[i];
      if (bank_release && (release_idx == BIDX_W'(i)) && (bank_st_q[i] == BANK_READY))
        bank_eff[i] = BANK_FREE;
    end
  end

  assign size_sel   = ((bank_size == '0) || (bank_size > STRIDE)) ? STRIDE : bank_size;
  assign write_live = wren_q && (state_q == ST_CAPTURE) && !frame_begin;
  assign complete   = write_live && (offset_q == (size_l_q - ADDR_W'(1)));
  assign next_bank  = cur_bank_q + 1'b1;
  assign next_free  = (bank_eff[next_bank] == BANK_FREE);
  assign drop_now   = complete && !next_free;
  assign capture_ok = (state_q == ST_CAPTURE) && !drop_now;

  cimg_pixel_packer #(
    .PIX_W        (PIX_W),
    .PIX_PER_WORD (PIX_PER_WORD)
  ) u_packer (
    .clock       (clock),
    .reset_n     (reset_n),
    .capture     (capture_ok),
    .frame_begin (frame_begin),
    .line_valid  (line_valid),
    .pad_en      (pad_en),
    .sensor_din  (sensor_din),
    .word_valid  (word_valid),
    .word        (word)
  );

  always_comb begin
    state_d       = state_q;
    cur_bank_d    = cur_bank_q;
    offset_d      = offset_q;
    size_l_d      = size_l_q;
    bank_st_d     = bank_eff;
    wren_d        = word_valid && capture_ok;
    wrdata_d      = (word_valid && capture_ok) ? word : wrdata_q;
    irq_d         = 1'b0;
    irq_bank_d    = irq_bank_q;
    overflow_d    = overflow_q;
    frame_short_d = frame_short_q;
    dropped_d     = dropped_q;
    cnt_d         = cnt_q;

    if (frame_begin) begin
      // a write already on the bus this cycle lands but is not accounted
      frame_short_d = (state_q != ST_IDLE) && (cnt_q < min_irq);
      cnt_d         = '0;
      offset_d      = '0;
      if (state_q == ST_CAPTURE) begin
        if (enable) begin
          size_l_d = size_sel;
        end else begin
          state_d               = ST_IDLE;
          bank_st_d[cur_bank_q] = BANK_FREE;
        end
      end else if (enable) begin
        size_l_d = size_sel;
        if (bank_eff[cur_bank_q] == BANK_FREE) begin
          state_d               = ST_CAPTURE;
          bank_st_d[cur_bank_q] = BANK_FILLING;
        end else begin
          state_d = ST_DROP;
          if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end else if (write_live) begin
      if (complete) begin
        bank_st_d[cur_bank_q] = BANK_READY;
        irq_d                 = 1'b1;
        irq_bank_d            = cur_bank_q;
        cur_bank_d            = next_bank;
        offset_d              = '0;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        if (next_free) begin
          bank_st_d[next_bank] = BANK_FILLING;
        end else begin
          overflow_d = 1'b1;
          state_d    = ST_DROP;
          if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
        end
      end else begin
        offset_d = offset_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cur_bank_q    <= '0;
      for (int i = 0; i < NUM_BANKS; i++) bank_st_q[i] <= BANK_FREE;
      offset_q      <= '0;
      size_l_q      <= STRIDE;
      wren_q        <= 1'b0;
      wrdata_q      <= '0;
      irq_q         <= 1'b0;
      irq_bank_q    <= '0;
      overflow_q    <= 1'b0;
      frame_short_q <= 1'b0;
      dropped_q     <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cur_bank_q    <= cur_bank_d;
      bank_st_q     <= bank_st_d;
      offset_q      <= offset_d;
      size_l_q      <= size_l_d;
      wren_q        <= wren_d;
      wrdata_q      <= wrdata_d;
      irq_q         <= irq_d;
      irq_bank_q    <= irq_bank_d;
      overflow_q    <= overflow_d;
      frame_short_q <= frame_short_d;
      dropped_q     <= dropped_d;
      cnt_q         <= cnt_d;
    end
  end

  // address follows the live bank/offset so back-to-back words need no bypass
  assign wr.buf_wren   = wren_q;
  assign wr.buf_wraddr = (STRIDE * ADDR_W'(cur_bank_q)) + offset_q;
  assign wr.buf_wrdata = wrdata_q;

  assign irq            = irq_q;
  assign irq_bank       = irq_bank_q;
  assign overflow       = overflow_q;
  assign frame_short    = frame_short_q;
  assign dropped_frames = dropped_q;

  generate
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_ready
      assign bank_ready[g] = (bank_st_q[g] == BANK_READY);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cimg_bank_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cimg_bank_writer : scoreboard bench for the CImgBuffer bank writer
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_cimg_bank_writer;

  localparam int PIX_W  = 8;
  localparam int PPW    = 4;
  localparam int ADDR_W = 14;
  localparam int NB     = 2;
  localparam int STRIDE = 8192;
  localparam int DATA_W = PIX_W * PPW;
  localparam int BIDX_W = 1;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [PIX_W-1:0]  sensor_din = '0;
  logic              frame_begin = 1'b0;
  logic              line_valid = 1'b0;
  logic              enable = 1'b0;
  logic              pad_en = 1'b0;
  logic [ADDR_W-1:0] bank_size = '0;
  logic [7:0]        min_irq = '0;
  logic              bank_release = 1'b0;
  logic [BIDX_W-1:0] release_idx = '0;
  logic              irq;
  logic [BIDX_W-1:0] irq_bank;
  logic [NB-1:0]     bank_ready;
  logic              overflow;
  logic              frame_short;
  logic [15:0]       dropped_frames;

  always #5 clock = ~clock;

  cimg_bank_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

  cimg_bank_writer #(
    .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .ADDR_W(ADDR_W),
    .NUM_BANKS(NB), .BANK_STRIDE(STRIDE)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sensor_din(sensor_din),
    .frame_begin(frame_begin), .line_valid(line_valid), .enable(enable),
    .pad_en(pad_en), .bank_size(bank_size), .min_irq(min_irq),
    .bank_release(bank_release), .release_idx(release_idx), .wr(wr_if),
    .irq(irq), .irq_bank(irq_bank), .bank_ready(bank_ready),
    .overflow(overflow), .frame_short(frame_short),
    .dropped_frames(dropped_frames)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_w   [$];
  logic [BIDX_W-1:0] exp_irq [$];
  int                checks   = 0;
  int                failures = 0;
  bit                auto_rel = 1'b0;
  int                m_bank, m_off, m_size;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: every bus write and irq is matched against the queues
  always @(negedge clock) begin
    wr_t               e;
    logic [BIDX_W-1:0] b;
    if (reset_n) begin
      if (wr_if.buf_wren) begin
        if (exp_w.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required none",
                   wr_if.buf_wraddr, wr_if.buf_wrdata);
        end else begin
          e = exp_w.pop_front();
          chk("wr_addr", 64'(wr_if.buf_wraddr), 64'(e.addr));
          chk("wr_data", 64'(wr_if.buf_wrdata), 64'(e.data));
        end
      end
      if (irq) begin
        if (exp_irq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_irq actual bank=%0d required none", irq_bank);
        end else begin
          b = exp_irq.pop_front();
          chk("irq_bank", 64'(irq_bank), 64'(b));
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    bank_release = 1'b0;
    if (auto_rel && irq) begin
      bank_release = 1'b1;
      release_idx  = irq_bank;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic model_reset(input int size);
    m_bank = 0;
    m_off  = 0;
    m_size = (size == 0 || size > STRIDE) ? STRIDE : size;
  endtask

  task automatic push_raw(input int addr, input logic [DATA_W-1:0] d);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = d;
    exp_w.push_back(e);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    push_raw(m_bank * STRIDE + m_off, d);
    if (m_off == m_size - 1) begin
      exp_irq.push_back(BIDX_W'(m_bank));
      m_bank = (m_bank + 1) % NB;
      m_off  = 0;
    end else begin
      m_off++;
    end
  endtask

  task automatic send_raw(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      line_valid = 1'b1;
      sensor_din = base + 8'(i);
      step();
    end
    line_valid = 1'b0;
  endtask

  task automatic send_words(input logic [7:0] base, input int n);
    for (int w = 0; w < n; w++) begin
      logic [7:0] v;
      v = base + 8'(4 * w);
      push_word({v + 8'd3, v + 8'd2, v + 8'd1, v});
      for (int k = 0; k < 4; k++) begin
        line_valid = 1'b1;
        sensor_din = v + 8'(k);
        step();
      end
    end
    line_valid = 1'b0;
  endtask

  task automatic begin_frame(input logic en);
    frame_begin = 1'b1;
    enable      = en;
    step();
    frame_begin = 1'b0;
    m_off       = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_w.delete();
    exp_irq.delete();
    line_valid = 1'b0;
    frame_begin = 1'b0;
    auto_rel = 1'b0;
    pad_en = 1'b0;
    idle(2);
    reset_n = 1'b1;
    step();
  endtask

  task automatic drain(input string name);
    idle(6);
    chk({name, "_sb_empty"}, 64'(exp_w.size() + exp_irq.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_bus"}, 64'({wr_if.buf_wren, wr_if.buf_wraddr, wr_if.buf_wrdata}), 64'd0);
    chk({name, "_status"},
        64'({irq, irq_bank, bank_ready, overflow, frame_short, dropped_frames}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk_all_zero("reset");

    // two lines of 16 samples, consumer frees each bank on its irq
    bank_size = 14'd4;
    auto_rel  = 1'b1;
    begin_frame(1'b1);
    push_raw(0, 32'h04030201); push_raw(1, 32'h08070605);
    push_raw(2, 32'h0C0B0A09); push_raw(3, 32'h100F0E0D);
    exp_irq.push_back(1'b0);
    push_raw(8192, 32'h14131211); push_raw(8193, 32'h18171615);
    push_raw(8194, 32'h1C1B1A19); push_raw(8195, 32'h201F1E1D);
    exp_irq.push_back(1'b1);
    send_raw(8'h01, 16);
    idle(3);
    send_raw(8'h11, 16);
    drain("basic");
    chk("basic_overflow", 64'(overflow), 64'd0);
    chk("basic_ready", 64'(bank_ready), 64'd0);

    // never release: second completion finds bank 0 READY
    do_reset();
    bank_size = 14'd4;
    model_reset(4);
    begin_frame(1'b1);
    send_words(8'h01, 8);
    send_raw(8'h21, 4);
    idle(6);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_dropped", 64'(dropped_frames), 64'd1);
    chk("ovf_ready", 64'(bank_ready), 64'b11);
    drain("ovf");
    bank_release = 1'b1;
    release_idx  = 1'b0;
    step();
    begin_frame(1'b1);
    send_words(8'h40, 1);
    drain("ovf_resume");
    chk("ovf_dropped_hold", 64'(dropped_frames), 64'd1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // asynchronous reset in the middle of a word
    send_raw(8'h50, 2);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_w.delete();
    exp_irq.delete();
    idle(2);
    reset_n = 1'b1;
    bank_size = 14'd4;
    model_reset(4);
    begin_frame(1'b1);
    send_words(8'h60, 1);
    drain("after_reset");

    // partial word at line end, padded then dropped
    do_reset();
    bank_size = 14'd8;
    pad_en = 1'b1;
    begin_frame(1'b1);
    push_raw(0, 32'h04030201);
    push_raw(1, 32'h00000605);
    send_raw(8'h01, 6);
    idle(3);
    pad_en = 1'b0;
    push_raw(2, 32'h14131211);
    send_raw(8'h11, 6);
    idle(4);
    drain("pad");

    // bank_size 0 wraps at the full stride
    do_reset();
    bank_size = 14'd0;
    model_reset(0);
    auto_rel = 1'b1;
    begin_frame(1'b1);
    send_words(8'h00, 8193);
    drain("stride");
    chk("stride_overflow", 64'(overflow), 64'd0);

    // release of the next bank on the completing write cycle wins
    do_reset();
    bank_size = 14'd4;
    model_reset(4);
    begin_frame(1'b1);
    send_words(8'h01, 4);
    idle(4);
    send_words(8'h11, 4);
    bank_release = 1'b1;
    release_idx  = 1'b0;
    step();
    send_words(8'h21, 1);
    drain("race");
    chk("race_overflow", 64'(overflow), 64'd0);
    chk("race_ready", 64'(bank_ready), 64'b10);
    chk("race_dropped", 64'(dropped_frames), 64'd0);

    // short-frame detection against min_irq
    do_reset();
    bank_size = 14'd1;
    min_irq   = 8'd5;
    auto_rel  = 1'b1;
    model_reset(1);
    begin_frame(1'b1);
    chk("short_first", 64'(frame_short), 64'd0);
    send_words(8'h01, 3);
    idle(6);
    begin_frame(1'b1);
    chk("short_three", 64'(frame_short), 64'd1);
    send_words(8'h31, 6);
    idle(6);
    begin_frame(1'b1);
    chk("short_six", 64'(frame_short), 64'd0);
    drain("short");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
